// File: rtl/gate_decision_sequencer.sv
// Queues per-packet allow/drop verdicts and hands them to the packet gate in order,
// issuing a default verdict when a packet head starves so the datapath cannot stall.
module gate_decision_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit DEFAULT_ALLOW  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          verdict_valid,
    input  logic                          verdict_allow,
    output logic                          verdict_ready,
    input  logic                          mon_tvalid,
    input  logic                          mon_tready,
    input  logic                          mon_tlast,
    input  logic                          cfg_enable,
    output logic                          decision_valid,
    output logic                          decision_allow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   cnt_decisions,
    output logic [31:0]                   cnt_timeouts,
    output logic [31:0]                   cnt_late_discard
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]   SKIP_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PRESENT,
        S_DEFAULT
    } state_t;

    state_t              state, state_next;
    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                sop;
    logic [15:0]         skip;
    logic [TW-1:0]       timer, timer_next;
    logic                beat, consume, wr_fire, push, discard, has_entry;
    logic                load, timeout, taken;

    assign beat          = mon_tvalid & mon_tready;
    assign consume       = sop & beat;
    assign verdict_ready = (count != FULL_LEVEL);
    assign wr_fire       = verdict_valid & verdict_ready;
    assign discard       = wr_fire & (skip != 16'd0);
    assign push          = wr_fire & (skip == 16'd0);
    assign has_entry     = (count != '0);

    assign decision_valid = (state != S_EMPTY);
    assign fifo_level     = count;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        timer_next = '0;
        load       = 1'b0;
        timeout    = 1'b0;
        taken      = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (cfg_enable && has_entry) begin
                    load       = 1'b1;
                    state_next = S_PRESENT;
                end else if (cfg_enable && sop && mon_tvalid) begin
                    if (timer == TIMER_LAST) begin
                        timeout    = 1'b1;
                        state_next = S_DEFAULT;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
            end
            default: begin
                if (consume) begin
                    taken = 1'b1;
                    if (cfg_enable && has_entry) begin
                        load       = 1'b1;
                        state_next = S_PRESENT;
                    end else begin
                        state_next = S_EMPTY;
                    end
                end
            end
        endcase
    end

    // NOTE: verdict storage has no reset; the pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= verdict_allow;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_EMPTY;
            timer            <= '0;
            sop              <= 1'b1;
            skip             <= 16'd0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            decision_allow   <= 1'b0;
            cnt_decisions    <= 32'd0;
            cnt_timeouts     <= 32'd0;
            cnt_late_discard <= 32'd0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            if (beat) sop <= mon_tlast;

            if (load)         decision_allow <= mem[rd_ptr];
            else if (timeout) decision_allow <= DEFAULT_ALLOW;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, load})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            // A timeout coinciding with a discard leaves the skip credit unchanged.
            unique case ({timeout, discard})
                2'b10:   if (skip != SKIP_MAX) skip <= skip + 16'd1;
                2'b01:   skip <= skip - 16'd1;
                default: skip <= skip;
            endcase

            if (taken)   cnt_decisions    <= cnt_decisions + 32'd1;
            if (timeout) cnt_timeouts     <= cnt_timeouts + 32'd1;
            if (discard) cnt_late_discard <= cnt_late_discard + 32'd1;
        end
    end

endmodule

// File: doc/gate_decision_sequencer.md
Name: gate_decision_sequencer

Overview:
- Sits between the flow classifier and the axis_packet_gate instance.
- Queues per-packet allow/drop verdicts in arrival order and presents them to the gate on decision_valid/decision_allow.
- Retires each verdict exactly when the gate accepts the first beat of a packet.
- If a packet head waits too long with no verdict, issues a configurable default verdict so the datapath cannot deadlock.

Parameters:
- FIFO_DEPTH, 8, verdict queue depth; power of 2, minimum 2.
- TIMEOUT_CYCLES, 1024, stall cycles before the default verdict is issued; minimum 2.
- DEFAULT_ALLOW, 0, verdict value used on timeout (0 = drop).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- verdict_valid  in  1  classifier verdict valid.
- verdict_allow  in  1  verdict value (1 = forward).
- verdict_ready  out  1  FIFO can accept a verdict.
- mon_tvalid  in  1  tap of gate s_axis_tvalid.
- mon_tready  in  1  tap of gate s_axis_tready.
- mon_tlast  in  1  tap of gate s_axis_tlast.
- cfg_enable  in  1  when 0, no new decision is presented.
- decision_valid  out  1  to gate decision_valid.
- decision_allow  out  1  to gate decision_allow.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued verdicts, excluding the presented one.
- cnt_decisions  out  32  decisions consumed by the gate.
- cnt_timeouts  out  32  default decisions issued.
- cnt_late_discard  out  32  verdicts discarded because a timeout already covered their packet.

Behaviour:
- Reset: all outputs are 0 except verdict_ready, which is 1. sop=1, skip=0, timer=0, FIFO empty, state EMPTY.
- Reset mid-operation clears everything immediately; in-flight verdicts are lost.
- Packet tracking: a beat is a cycle with mon_tvalid & mon_tready. On each beat, sop <= mon_tlast. consume = sop & beat.
- Verdict write: occurs when verdict_valid & verdict_ready. verdict_ready = FIFO not full.
  - If skip>0, the written verdict is discarded instead of queued: skip decrements and cnt_late_discard increments.
- States:
  - EMPTY: decision_valid=0.
    - If cfg_enable and a queued verdict exists, load the head into decision_allow, set decision_valid=1 and go to PRESENT (one cycle after the write).
    - Otherwise, if cfg_enable & sop & mon_tvalid, increment timer. At timer==TIMEOUT_CYCLES-1, set decision_allow=DEFAULT_ALLOW, decision_valid=1, cnt_timeouts++, skip++, go to DEFAULT. Timer clears on leaving EMPTY or when the condition drops.
  - PRESENT / DEFAULT: decision_valid and decision_allow are held stable until consume.
    - On consume: cnt_decisions++.
    - If cfg_enable and the FIFO holds an entry, load the next head on the same edge and stay in PRESENT (zero-bubble back-to-back). Otherwise drop decision_valid and go to EMPTY.
- cfg_enable=0: a presented decision stays until consumed; nothing new is loaded; the timer is held at 0.
- Simultaneous write and pop: both occur; fifo_level is unchanged. A write to a full FIFO is impossible because verdict_ready=0.
- A write that coincides with a timeout edge, with skip==0 before the edge, is queued normally. skip increments on that edge, so the next verdict written is discarded.
- skip saturates at 2^16-1. All counters wrap at 2^32.
- consume observed in EMPTY (gate misuse) is ignored, with no counter change.

Test Plan:
- Single-beat packets: write allow=1,0,1; drive three 1-beat packets -> decision_allow sequence 1,0,1 with no bubble between consumes; cnt_decisions=3; fifo_level returns to 0.
- Multi-beat packet: verdict 1; 4-beat packet with mon_tready toggling -> exactly one consume (first beat); decision_valid falls on the first beat's edge; cnt_decisions=1.
- FIFO full: write 9 verdicts with no packets and FIFO_DEPTH=8 -> verdict_ready=0 after 9 accepted (1 presented + 8 queued); fifo_level=8. One consume -> verdict_ready=1 next cycle.
- Timeout: TIMEOUT_CYCLES=16, packet head valid and no verdict -> decision_valid=1 with allow=DEFAULT_ALLOW after 16 cycles; cnt_timeouts=1. A verdict written later is discarded and cnt_late_discard=1.
- cfg_enable=0 with 2 queued verdicts and a packet waiting -> decision_valid stays 0 and no timeout fires. Re-enable -> decision presented on the second cycle after enable rises.
- Reset mid-packet with 3 queued -> all outputs at reset values. After release, a fresh verdict/packet pair works, with sop=1 assumed.
